lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 89 ++++++++
 tb/tb_lsu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: load/store unit with sign/zero-extended sub-word loads and read-modify-write sub-word stores
module lsu #(
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
  state_t state, nxt;
  logic [1:0] lane, size;
  logic we, uns, ill;
  logic [4:0] sh;
  logic [31:0] bsh, ld, mask, merged;
  logic [15:0] half;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: errors skip memory, word stores skip the read, everything else reads first
  always_comb begin
    ill = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    nxt = state == IDLE ? (req_valid ? (ill ? RESP : (req_we && req_size == 2'b10) ? WR : RD) : IDLE)
        : state == RD   ? CAP
        : state == CAP  ? (we ? WR : RESP)
        : state == WR   ? RESP
        : IDLE;
  end
  // handshake and memory strobes decoded purely from the state
  always_comb begin
    req_ready  = state == IDLE;
    mem_re     = state == RD;
    mem_we     = state == WR;
    resp_valid = state == RESP;
  end
  // lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    sh     = {lane, 3'b000};
    bsh    = mem_rdata >> sh;
    half   = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld     = size == 2'b00 ? {{24{~uns & bsh[7]}}, bsh[7:0]}
           : size == 2'b01 ? {{16{~uns & half[15]}}, half}
           : mem_rdata;
    mask   = (size == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    merged = (mem_rdata & ~mask) | ((mem_wdata << sh) & mask);
  end
  // request capture, RMW merge into the write word, and response latching on RESP entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lane       <= '0;
      size       <= '0;
      we         <= 1'b0;
      uns        <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        lane      <= req_addr[1:0];
        size      <= req_size;
        we        <= req_we;
        uns       <= req_unsigned;
        mem_addr  <= {{(32-AW){1'b0}}, req_addr[AW+1:2]};
        mem_wdata <= req_wdata;
      end
      if (state == CAP && we) mem_wdata <= merged;
      if (nxt == RESP) begin
        resp_err   <= state == IDLE;
        resp_rdata <= (state == CAP && !we) ? ld : 32'h0;
      end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed scoreboard bench for lsu against a behavioural one-cycle-latency memory
module tb_lsu;
  logic clk, rst_n, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic resp_valid, resp_err, mem_re, mem_we;
  logic [31:0] mem [256];
  int checks = 0, failures = 0, cyc = 0, act = 0, a0;
  typedef struct {logic err; logic [31:0] rd; int due;} exp_t;
  exp_t q[$];

  lsu #(.AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory: write on mem_we, read data one cycle after mem_re, zero otherwise
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_re ? mem[mem_addr[7:0]] : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // response monitor pops the scoreboard and checks data, error flag and arrival cycle
  always @(negedge clk) begin
    exp_t e;
    chk("re_we_excl", {31'b0, mem_re & mem_we}, 0);
    if (mem_re | mem_we) begin
      act++;
      chk("addr_hi", {8'b0, mem_addr[31:8]}, 0);
    end
    if (resp_valid) begin
      chk("resp_expected", {31'b0, q.size() != 0}, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_cycle", cyc, e.due);
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] wd,
                      input logic xerr, input logic [31:0] xrd, input int lat, input bit push = 1);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {31'b0, n < 20}, 1);
    if (push && n < 20) q.push_back('{xerr, xrd, cyc + lat});
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    req_valid = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1;
    #1 chk("post_rst_ready", {31'b0, req_ready}, 1);
    send(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2);
    send(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3);
    drain();
    chk("mem4_word_store", mem[4], 32'hDEADBEEF);
    send(1, 2'b10, 0, 32'h410, 32'h12345678, 0, 32'h0, 2);
    drain();
    chk("wrap_store", mem[4], 32'h12345678);
    mem[4] = 32'h11223380;
    mem[5] = 32'h9ABC0000;
    send(0, 2'b00, 0, 32'h10, 32'h0, 0, 32'hFFFFFF80, 3);
    send(0, 2'b00, 1, 32'h10, 32'h0, 0, 32'h00000080, 3);
    send(0, 2'b01, 0, 32'h12, 32'h0, 0, 32'h00001122, 3);
    send(0, 2'b01, 1, 32'h16, 32'h0, 0, 32'h00009ABC, 3);
    send(0, 2'b01, 0, 32'h16, 32'h0, 0, 32'hFFFF9ABC, 3);
    send(0, 2'b00, 0, 32'h17, 32'h0, 0, 32'hFFFFFF9A, 3);
    send(0, 2'b00, 1, 32'h11, 32'h0, 0, 32'h00000033, 3);
    drain();
    chk("rdata_hold", resp_rdata, 32'h00000033);
    mem[4] = 32'h11223344;
    send(1, 2'b00, 0, 32'h11, 32'hFFFFFFAA, 0, 32'h0, 4);
    drain();
    chk("rmw_byte", mem[4], 32'h1122AA44);
    send(1, 2'b01, 0, 32'h12, 32'h1234BEEF, 0, 32'h0, 4);
    drain();
    chk("rmw_half", mem[4], 32'hBEEFAA44);
    send(0, 2'b00, 1, 32'h10, 32'h0, 0, 32'h00000044, 3);
    drain();
    a0 = act;
    send(0, 2'b10, 0, 32'h13, 32'h0, 1, 32'h0, 1);
    send(1, 2'b01, 0, 32'h11, 32'hFFFF, 1, 32'h0, 1);
    send(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 1);
    drain();
    chk("err_no_mem_access", act, a0);
    chk("err_mem_unchanged", mem[4], 32'hBEEFAA44);
    send(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hBEEFAA44, 3);
    send(1, 2'b10, 0, 32'h14, 32'hCAFEF00D, 0, 32'h0, 2);
    send(1, 2'b00, 0, 32'h15, 32'h00000077, 0, 32'h0, 4);
    send(0, 2'b10, 0, 32'h14, 32'h0, 0, 32'hCAFE770D, 3);
    drain();
    chk("b2b_mem5", mem[5], 32'hCAFE770D);
    chk("b2b_hold", resp_rdata, 32'hCAFE770D);
    send(1, 2'b00, 0, 32'h10, 32'h00000055, 0, 32'h0, 4, 0);
    @(negedge clk);
    chk("abort_rd_state", {31'b0, mem_re}, 1);
    @(negedge clk);
    req_valid = 0;
    rst_n = 0;
    #1;
    chk("abort_mem_re", {31'b0, mem_re}, 0);
    chk("abort_mem_we", {31'b0, mem_we}, 0);
    chk("abort_resp_valid", {31'b0, resp_valid}, 0);
    chk("abort_resp_err", {31'b0, resp_err}, 0);
    chk("abort_rdata", resp_rdata, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("abort_ready", {31'b0, req_ready}, 1);
    repeat (3) @(negedge clk);
    chk("abort_mem4", mem[4], 32'hBEEFAA44);
    chk("abort_no_resp", q.size(), 0);
    send(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hBEEFAA44, 3);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
